// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the AES round datapath.
//   MODE_FWD / MODE_INV / MODE_BYP : 2-bit ShiftRows mode encoding
//   row_shift(nb, r)               : cyclic shift amount of row r for an nb-column state
//   byte_idx(r, c)                 : byte position of (row, column) in column-major order
package aes_pkg;

  localparam logic [1:0] MODE_FWD = 2'b00;
  localparam logic [1:0] MODE_INV = 2'b01;
  localparam logic [1:0] MODE_BYP = 2'b10;

  // Rijndael: rows shift 0,1,2,3 for Nb = 4/6; 256-bit blocks use 0,1,3,4.
  function automatic int row_shift(input int nb, input int r);
    int s;
    if ((nb == 32'sd8) && (r >= 32'sd2)) begin
      s = r + 32'sd1;
    end else begin
      s = r;
    end
    return s;
  endfunction

  // Byte 0 is the MSB byte; bytes fill columns top to bottom.
  function automatic int byte_idx(input int r, input int c);
    return (32'sd4 * c) + r;
  endfunction

endpackage

// File: rtl/shiftrow_perm.sv
// shiftrow_perm: combinational ShiftRows / InvShiftRows / bypass byte permutation.
//   i_data [32*NB-1:0] : input state, byte 0 in the MSBs, column-major
//   i_mode [1:0]       : MODE_FWD, MODE_INV, anything else bypasses
//   o_data [32*NB-1:0] : permuted state
module shiftrow_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] i_data,
  input  logic [1:0]       i_mode,
  output logic [32*NB-1:0] o_data
);

  localparam int W = 32 * NB;

  logic [W-1:0] w_fwd;
  logic [W-1:0] w_inv;

  if ((NB != 32'sd4) && (NB != 32'sd6) && (NB != 32'sd8)) begin : g_bad_nb
    $error("shiftrow_perm: NB must be 4, 6 or 8");
  end

  // Pure wiring: each output byte selects one fixed input byte per direction.
  // The inverse source column adds NB before the modulo so the index never goes negative.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int S    = row_shift(NB, r);
      localparam int DST  = byte_idx(r, c);
      localparam int FSRC = byte_idx(r, (c + S) % NB);
      localparam int ISRC = byte_idx(r, (c + NB - S) % NB);
      assign w_fwd[W-1-8*DST -: 8] = i_data[W-1-8*FSRC -: 8];
      assign w_inv[W-1-8*DST -: 8] = i_data[W-1-8*ISRC -: 8];
    end
  end

  // Mode select; both bypass encodings fall to the default arm.
  always_comb begin
    o_data = i_data;
    case (i_mode)
      MODE_FWD: o_data = w_fwd;
      MODE_INV: o_data = w_inv;
      default:  o_data = i_data;
    endcase
  end

endmodule

// File: rtl/shiftrow_unit.sv
// shiftrow_unit: registered ShiftRows/InvShiftRows engine with an output FIFO.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake; in_ready depends only on rst and stored count
//   in_data, in_mode     : state block and mode (00 fwd, 01 inv, 1x bypass)
//   in_tag               : sideband carried unchanged alongside the block
//   out_valid / out_ready: output handshake; head entry held while stalled
//   out_data, out_tag    : head-of-FIFO block and its tag
module shiftrow_unit
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*NB-1:0]    in_data,
  input  logic [1:0]          in_mode,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*NB-1:0]    out_data,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int W  = 32 * NB;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(32'd1);
  localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(32'd0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(32'd0);

  if ((DEPTH < 32'sd2) || ((DEPTH & (DEPTH - 32'sd1)) != 32'sd0)) begin : g_bad_depth
    $error("shiftrow_unit: DEPTH must be a power of two, at least 2");
  end

  logic [W-1:0]     r_mem     [DEPTH];
  logic [TAG_W-1:0] r_tag_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  logic [W-1:0]     w_perm;
  logic             w_push;
  logic             w_pop;

  shiftrow_perm #(.NB(NB)) u_perm (
    .i_data (in_data),
    .i_mode (in_mode),
    .o_data (w_perm)
  );

  // Handshake flags come from registered count only; reset masks both.
  assign in_ready  = !rst && (r_count != CNT_FULL);
  assign out_valid = !rst && (r_count != CNT_ZERO);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign out_data  = r_mem[r_rptr];
  assign out_tag   = r_tag_mem[r_rptr];

  // Storage array: written on accept, no reset needed since out_valid guards it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr]     <= w_perm;
      r_tag_mem[r_wptr] <= in_tag;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= PTR_ZERO;
      r_rptr  <= PTR_ZERO;
      r_count <= CNT_ZERO;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftrow_unit.sv
module tb_shiftrow_unit;
  import aes_pkg::*;

  localparam int W4 = 128;
  localparam int W6 = 192;
  localparam int W8 = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W4-1:0] in_data, out_data;
  logic [1:0]    in_mode;
  logic [3:0]    in_tag, out_tag;

  logic          d6_in_valid, d6_in_ready, d6_out_valid;
  logic          d6_out_ready = 1'b1;
  logic [W6-1:0] d6_in_data, d6_out_data;
  logic [1:0]    d6_in_mode;
  logic [3:0]    d6_in_tag, d6_out_tag;

  logic          d8_in_valid, d8_in_ready, d8_out_valid;
  logic          d8_out_ready = 1'b1;
  logic [W8-1:0] d8_in_data, d8_out_data;
  logic [1:0]    d8_in_mode;
  logic [3:0]    d8_in_tag, d8_out_tag;

  shiftrow_unit #(.NB(4), .DEPTH(2), .TAG_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  shiftrow_unit #(.NB(6), .DEPTH(2), .TAG_W(4)) u_dut6 (
    .clk(clk), .rst(rst),
    .in_valid(d6_in_valid), .in_ready(d6_in_ready), .in_data(d6_in_data),
    .in_mode(d6_in_mode), .in_tag(d6_in_tag),
    .out_valid(d6_out_valid), .out_ready(d6_out_ready),
    .out_data(d6_out_data), .out_tag(d6_out_tag)
  );

  shiftrow_unit #(.NB(8), .DEPTH(2), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(d8_in_valid), .in_ready(d8_in_ready), .in_data(d8_in_data),
    .in_mode(d8_in_mode), .in_tag(d8_in_tag),
    .out_valid(d8_out_valid), .out_ready(d8_out_ready),
    .out_data(d8_out_data), .out_tag(d8_out_tag)
  );

  typedef struct {
    logic [W4-1:0] d;
    logic [3:0]    t;
  } sb_ent_t;

  sb_ent_t sb[$];
  int n_total = 0;
  int n_pass  = 0;

  function automatic logic [W4-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_mode = MODE_BYP; in_tag = 4'h0; out_ready = 1'b0;
    d6_in_valid = 1'b0; d6_in_data = '0; d6_in_mode = MODE_BYP; d6_in_tag = 4'h0;
    d8_in_valid = 1'b0; d8_in_data = '0; d8_in_mode = MODE_BYP; d8_in_tag = 4'h0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({in_ready, d6_in_ready, d8_in_ready} !== 3'b000)
      $display("FAIL reset_in_ready_low: got %b required 000", {in_ready, d6_in_ready, d8_in_ready});
    else n_pass++;
    n_total++;
    if ({out_valid, d6_out_valid, d8_out_valid} !== 3'b000)
      $display("FAIL reset_out_valid_low: got %b required 000", {out_valid, d6_out_valid, d8_out_valid});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({in_ready, d6_in_ready, d8_in_ready} !== 3'b111)
      $display("FAIL post_reset_in_ready: got %b required 111", {in_ready, d6_in_ready, d8_in_ready});
    else n_pass++;
    n_total++;
    if ({out_valid, d6_out_valid, d8_out_valid} !== 3'b000)
      $display("FAIL post_reset_out_valid: got %b required 000", {out_valid, d6_out_valid, d8_out_valid});
    else n_pass++;
  endtask

  task automatic test_vectors();
    logic [W4-1:0] vin = 128'h00112233445566778899aabbccddeeff;
    logic [W4-1:0] exp_d [4];
    logic [1:0]    modes [4];
    logic [3:0]    tag;
    exp_d = '{128'h0055aaff4499ee3388dd2277cc1166bb,
              128'h00ddaa774411eebb885522ffcc996633,
              128'h00112233445566778899aabbccddeeff,
              128'h00112233445566778899aabbccddeeff};
    modes = '{2'b00, 2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 4; i++) begin
      tag = 4'(i + 3);
      @(negedge clk);
      in_valid = 1'b1; in_data = vin; in_mode = modes[i]; in_tag = tag; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_total++;
      if (out_valid !== 1'b1) $display("FAIL vec%0d_latency: got out_valid=%b required 1", i, out_valid);
      else n_pass++;
      n_total++;
      if (out_data !== exp_d[i]) $display("FAIL vec%0d_data: got %h required %h", i, out_data, exp_d[i]);
      else n_pass++;
      n_total++;
      if (out_tag !== tag) $display("FAIL vec%0d_tag: got %h required %h", i, out_tag, tag);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL vec%0d_drained: got out_valid=%b required 0", i, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic          exp_rdy [3];
    logic [W4-1:0] blk [3];
    logic          pending;
    int            n_out;
    sb_ent_t       e;
    exp_rdy = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) blk[i] = rand128();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = blk[i]; in_mode = MODE_BYP; in_tag = 4'(i + 1);
      n_total++;
      if (in_ready !== exp_rdy[i]) $display("FAIL bp_in_ready_%0d: got %b required %b", i, in_ready, exp_rdy[i]);
      else n_pass++;
      if (in_valid && in_ready) sb.push_back('{blk[i], 4'(i + 1)});
    end
    pending = !exp_rdy[2];
    n_out = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = pending; in_data = blk[2]; in_tag = 4'd3;
      if (out_valid && out_ready) begin
        n_out++;
        n_total++;
        if (sb.size() == 0) $display("FAIL bp_extra_output: got tag %h required no output", out_tag);
        else begin
          e = sb.pop_front();
          if ({out_tag, out_data} !== {e.t, e.d})
            $display("FAIL bp_order: got %h/%h required %h/%h", out_tag, out_data, e.t, e.d);
          else n_pass++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{blk[2], 4'd3});
        pending = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_total++;
    if (n_out !== 3) $display("FAIL bp_output_count: got %0d required 3", n_out);
    else n_pass++;
    n_total++;
    if (sb.size() !== 0) $display("FAIL bp_leftover: got %0d required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_streaming();
    logic [W4-1:0] d;
    sb_ent_t       e;
    int            n_out = 0;
    for (int i = 0; i < 102; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      d = rand128();
      in_valid = (i < 100); in_data = d; in_mode = MODE_BYP; in_tag = 4'(i);
      if (i >= 1 && i < 101) begin
        n_total++;
        if ({out_valid, in_ready} !== 2'b11)
          $display("FAIL stream_flags_c%0d: got valid/ready=%b required 11", i, {out_valid, in_ready});
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        n_total++;
        if (sb.size() == 0) $display("FAIL stream_extra_output: got tag %h required no output", out_tag);
        else begin
          e = sb.pop_front();
          if ({out_tag, out_data} !== {e.t, e.d})
            $display("FAIL stream_order: got %h/%h required %h/%h", out_tag, out_data, e.t, e.d);
          else n_pass++;
        end
      end
      if (in_valid && in_ready) sb.push_back('{d, 4'(i)});
    end
    in_valid = 1'b0;
    n_total++;
    if (n_out !== 100) $display("FAIL stream_count: got %0d required 100", n_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [W4-1:0] d;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_data = rand128(); in_mode = MODE_BYP; in_tag = 4'(i + 12);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_total++;
    if ({in_ready, out_valid} !== 2'b00) $display("FAIL rst_mid_during: got ready/valid=%b required 00", {in_ready, out_valid});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    n_total++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL rst_mid_after: got ready/valid=%b required 10", {in_ready, out_valid});
    else n_pass++;
    d = 128'h00112233445566778899aabbccddeeff;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_mode = MODE_FWD; in_tag = 4'h9; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, out_tag, out_data} !== {1'b1, 4'h9, 128'h0055aaff4499ee3388dd2277cc1166bb})
      $display("FAIL rst_mid_new_block: got %b/%h/%h required 1/9/0055aaff4499ee3388dd2277cc1166bb", out_valid, out_tag, out_data);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL rst_mid_no_old: got out_valid=%b required 0", out_valid);
    else n_pass++;
  endtask

  task automatic rt_drive(input int nb, input logic [W8-1:0] d, input logic [1:0] m);
    in_valid = (nb == 4); in_data = d[W4-1:0]; in_mode = m; out_ready = 1'b1;
    d6_in_valid = (nb == 6); d6_in_data = d[W6-1:0]; d6_in_mode = m;
    d8_in_valid = (nb == 8); d8_in_data = d; d8_in_mode = m;
  endtask

  task automatic rt_read(input int nb, output logic ov, output logic [W8-1:0] q);
    case (nb)
      4:       begin ov = out_valid;    q = {128'h0, out_data};   end
      6:       begin ov = d6_out_valid; q = {64'h0, d6_out_data}; end
      default: begin ov = d8_out_valid; q = d8_out_data;          end
    endcase
  endtask

  task automatic test_roundtrip();
    logic [W8-1:0] orig, fwd, got, mask;
    logic          ov;
    int            nb;
    for (int k = 0; k < 3; k++) begin
      nb = (k == 0) ? 4 : (k == 1) ? 6 : 8;
      mask = (nb == 8) ? '1 : ((256'h1 << (32 * nb)) - 256'h1);
      for (int n = 0; n < 3; n++) begin
        orig = {rand128(), rand128()} & mask;
        @(negedge clk);
        rt_drive(nb, orig, MODE_FWD);
        @(negedge clk);
        rt_drive(0, orig, MODE_BYP);
        rt_read(nb, ov, fwd);
        n_total++;
        if (ov !== 1'b1) $display("FAIL rt_nb%0d_fwd_valid: got %b required 1", nb, ov);
        else n_pass++;
        if (nb == 8) begin
          n_total++;
          if (fwd[231:224] !== orig[103:96])
            $display("FAIL rt_nb8_r3c0: got %h required %h", fwd[231:224], orig[103:96]);
          else n_pass++;
        end
        if (nb == 6) begin
          n_total++;
          if (fwd[23:16] !== orig[183:176])
            $display("FAIL rt_nb6_r1c5: got %h required %h", fwd[23:16], orig[183:176]);
          else n_pass++;
        end
        @(negedge clk);
        rt_drive(nb, fwd, MODE_INV);
        @(negedge clk);
        rt_drive(0, orig, MODE_BYP);
        rt_read(nb, ov, got);
        n_total++;
        if ({ov, got} !== {1'b1, orig})
          $display("FAIL rt_nb%0d_roundtrip: got %b/%h required 1/%h", nb, ov, got, orig);
        else n_pass++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    test_roundtrip();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shiftrow_unit.md
Name: shiftrow_unit

Overview:
Parametrised, registered ShiftRows/InvShiftRows engine for the AES/Rijndael datapath. It is the successor to the fixed 128-bit combinational inverse shift. It supports Rijndael block widths of Nb = 4, 6 or 8 columns, runtime forward/inverse/bypass mode, a valid/ready handshake and an output FIFO for back-pressure. It sits between SubBytes/InvSubBytes and MixColumns/AddRoundKey in the round pipeline.

Parameters:
NB, 4, state columns (legal values 4, 6, 8); data width W = 32*NB.
DEPTH, 2, output FIFO entries; power of two, at least 2.
TAG_W, 4, width of the sideband tag carried alongside each block (round index or stream id).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  input block valid.
in_ready  out  1  unit can accept a block this cycle.
in_data  in  W  input state.
in_mode  in  2  00 = forward ShiftRows; 01 = inverse; 10 and 11 = bypass.
in_tag  in  TAG_W  sideband, passed through unchanged.
out_valid  out  1  output block valid.
out_ready  in  1  downstream accepts the output.
out_data  out  W  shifted state.
out_tag  out  TAG_W  tag of the block on out_data.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- State layout: byte k occupies bits [W-1-8k : W-8-8k], so byte 0 is the MSB byte. Byte k maps to row r = k mod 4 and column c = k div 4 (column-major, FIPS-197 order).
- Row shift s(r):
  - NB = 4 or 6: s = 0, 1, 2, 3.
  - NB = 8: s = 0, 1, 3, 4.
- Forward: out[r][c] = in[r][(c + s(r)) mod NB].
- Inverse: out[r][c] = in[r][(c - s(r)) mod NB]. Use a modulo add, never a negative index.
- Bypass: out = in.
- Permutation is combinational on in_data and in_mode. The permuted word and the tag are written into the FIFO on accept.
- Accept condition: in_valid && in_ready.
- in_ready = (count != DEPTH). It is a function of registered count only, with no combinational path from out_ready.
- Pop condition: out_valid && out_ready.
- out_valid = (count != 0). out_data and out_tag come from the head entry and are held stable while out_valid && !out_ready.
- Latency: a block accepted at edge N is visible on out_valid/out_data after edge N, i.e. one cycle.
- Throughput: one block per cycle while out_ready stays high.
- Simultaneous push and pop:
  - count unchanged; read and write pointers both advance.
  - When count == DEPTH, no push happens because in_ready = 0, even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH. count is clog2(DEPTH)+1 bits wide.
- Ordering: strict FIFO, with tags kept aligned to their data.
- Reset values: count = 0, pointers = 0, out_valid = 0, in_ready = 1 after the reset edge.
- While rst is high, in_ready is forced to 0 and out_valid to 0.
- Reset mid-stream: all queued blocks are discarded. out_data content after reset is don't-care and must not be checked while out_valid = 0.
- Illegal NB is stopped at elaboration with a generate-time error.

Decomposition:
- Shared package aes_pkg holds:
  - the mode encoding constants MODE_FWD = 2'b00, MODE_INV = 2'b01, MODE_BYP = 2'b10;
  - the function row_shift(nb, r);
  - the function byte_idx(r, c).
- One sub-module: shiftrow_perm (pure combinational, parameters NB, inputs data and mode), generated from the package functions.
- The FIFO is inline in shiftrow_unit.

Test Plan:
- NB=4, FWD, in_data = 00112233445566778899aabbccddeeff, out_ready = 1 -> one cycle later out_data = 0055aaff4499ee3388dd2277cc1166bb, with out_tag equal to in_tag.
- NB=4, INV, same input -> out_data = 00ddaa774411eebb885522ffcc996633. Bypass mode -> out_data equals the input.
- Round trip for NB = 4, 6, 8: feed random blocks through FWD then INV, re-fed through the unit -> output equals the original. For NB=8 FWD, out row 3 column 0 equals input byte 19.
- Back-pressure, DEPTH=2: hold out_ready = 0 and push 3 blocks -> in_ready drops after the 2nd accept and the 3rd is stalled. Release out_ready -> blocks emerge in order with correct tags and no loss or duplicate.
- Full streaming: in_valid = out_ready = 1 for 100 cycles with tag = cycle count -> one output per cycle, tags consecutive, count stays at 1.
- Reset mid-operation: fill the FIFO, assert rst for one cycle -> out_valid = 0 and in_ready = 0 during reset, then in_ready = 1 and out_valid = 0. The next accepted block emerges after 1 cycle with none of the old blocks.
